// File: rtl/write_buffer_pkg.sv
// Shared types and defaults for the pixel write-back buffer.
package write_buffer_pkg;
   typedef enum logic [1:0] {WB_FILL, WB_DRAIN, WB_DONE} wb_state_t;
   localparam int PIXEL_W_DEF     = 24;
   localparam int ADDR_STRIDE_DEF = 4;
endpackage

// File: rtl/write_buffer_pixel_store.sv
// DEPTH x PIXEL_W register file: one synchronous write port, one async read port.
// Write lands on the clock edge; read reflects stored contents combinationally, no backpressure.
module pixel_store #(
   parameter int DEPTH   = 8,
   parameter int PIXEL_W = 24,
   parameter int AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic [AW-1:0]      waddr_i,
   input  logic [PIXEL_W-1:0] wdata_i,
   input  logic [AW-1:0]      raddr_i,
   output logic [PIXEL_W-1:0] rdata_o
);
   logic [PIXEL_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/write_buffer.sv
// Collects DEPTH pixels (or fewer on flush) and drains them as single-beat Avalon writes at consecutive addresses.
// First write request 1 cycle after the filling pixel/flush; waitrequest holds the beat, ready=0 outside FILL.
module write_buffer
   import write_buffer_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int PIXEL_W     = PIXEL_W_DEF,
   parameter int ADDR_W      = 32,
   parameter int ADDR_STRIDE = ADDR_STRIDE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               addr_load,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic               pixel_valid,
   input  logic [PIXEL_W-1:0] pixel_in,
   input  logic               flush,
   output logic               ready,
   output logic               master_write,
   output logic [ADDR_W-1:0]  master_address,
   output logic [PIXEL_W-1:0] master_writedata,
   input  logic               master_waitrequest,
   output logic               done_write,
   output logic               busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_state_t         state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic              ready_q, master_write_q, busy_q, done_q;
   logic              accept;

   assign accept = pixel_valid && ready_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cur_addr_d = cur_addr_q;
      unique case (state_q)
         WB_FILL: begin
            if (addr_load) cur_addr_d = base_addr;
            if (accept) begin
               wr_ptr_d = wr_ptr_q + PW'(1);
               count_d  = count_q + CW'(1);
            end
            // count_d already includes a pixel accepted alongside the flush
            if (count_d == CW'(DEPTH) || (flush && count_d != '0)) state_d = WB_DRAIN;
         end
         WB_DRAIN: begin
            if (!master_waitrequest) begin
               rd_ptr_d   = rd_ptr_q + PW'(1);
               cur_addr_d = cur_addr_q + ADDR_W'(ADDR_STRIDE);
               count_d    = count_q - CW'(1);
               if (count_q == CW'(1)) state_d = WB_DONE;
            end
         end
         WB_DONE: begin
            state_d  = WB_FILL;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
         end
         default: state_d = WB_FILL;
      endcase
   end

   // Outputs are registered from next state so no input reaches them combinationally
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= WB_FILL;
         count_q        <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         cur_addr_q     <= '0;
         ready_q        <= 1'b1;
         master_write_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         cur_addr_q     <= cur_addr_d;
         ready_q        <= (state_d == WB_FILL) && (count_d < CW'(DEPTH));
         master_write_q <= (state_d == WB_DRAIN);
         busy_q         <= (state_d == WB_DRAIN);
         done_q         <= (state_d == WB_DONE);
      end
   end

   pixel_store #(.DEPTH(DEPTH), .PIXEL_W(PIXEL_W), .AW(PW)) u_store (
      .clk     (clk),
      .rst     (rst),
      .we_i    (accept),
      .waddr_i (wr_ptr_q),
      .wdata_i (pixel_in),
      .raddr_i (rd_ptr_q),
      .rdata_o (master_writedata)
   );

   assign ready          = ready_q;
   assign master_write   = master_write_q;
   assign master_address = cur_addr_q;
   assign busy           = busy_q;
   assign done_write     = done_q;
endmodule

// File: tb/tb_write_buffer.sv
// Scoreboarded bench for write_buffer: stimulus pushes expected beats, a negedge monitor checks them.
module tb_write_buffer;
   typedef struct {
      logic [31:0] addr;
      logic [23:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        addr_load = 1'b0;
   logic [31:0] base_addr = '0;
   logic        pixel_valid = 1'b0;
   logic [23:0] pixel_in = '0;
   logic        flush = 1'b0;
   logic        ready, master_write, done_write, busy;
   logic [31:0] master_address;
   logic [23:0] master_writedata;
   logic        master_waitrequest = 1'b0;

   int          vectors = 0;
   int          miscompares = 0;
   int          done_cnt = 0;
   int          write_cycles = 0;
   int          acc_cnt = 0;
   beat_t       exp_q[$];
   logic [31:0] exp_addr = '0;

   write_buffer dut (
      .clk                (clk),
      .rst                (rst),
      .addr_load          (addr_load),
      .base_addr          (base_addr),
      .pixel_valid        (pixel_valid),
      .pixel_in           (pixel_in),
      .flush              (flush),
      .ready              (ready),
      .master_write       (master_write),
      .master_address     (master_address),
      .master_writedata   (master_writedata),
      .master_waitrequest (master_waitrequest),
      .done_write         (done_write),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every presented beat must match the queue head; pop only when accepted.
   always @(negedge clk) begin
      if (!rst) begin
         if (master_write) begin
            write_cycles++;
            if (exp_q.size() == 0) begin
               check("unexpected_write_addr", master_address, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check("beat_addr", master_address, exp_q[0].addr);
               check("beat_data", master_writedata, exp_q[0].data);
               if (!master_waitrequest) begin
                  void'(exp_q.pop_front());
                  acc_cnt++;
               end
            end
         end
         if (done_write) begin
            done_cnt++;
            check("done_with_beats_pending", exp_q.size(), 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_addr(input logic [31:0] a);
      base_addr = a;
      addr_load = 1'b1;
      exp_addr  = a;
      tick();
      addr_load = 1'b0;
   endtask

   task automatic send_pixel(input logic [23:0] p);
      beat_t b;
      check("ready_before_pixel", ready, 1);
      pixel_valid = 1'b1;
      pixel_in    = p;
      b.addr = exp_addr;
      b.data = p;
      exp_q.push_back(b);
      exp_addr = exp_addr + 32'd4;
      tick();
      pixel_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int start = done_cnt;
      bit got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done_cnt > start) begin
            got = 1'b1;
            break;
         end
      end
      check(name, got, 1);
      check("done_pulses", done_cnt - start, 1);
      check("ready_after_done", ready, 1);
      check("queue_empty_after_done", exp_q.size(), 0);
   endtask

   initial begin
      int wc;
      int dc;
      bit got;
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
      $fatal(1);
   end

   initial begin
      int wc;
      int dc;
      bit got;
      // Reset state
      rst = 1'b1;
      repeat (2) tick();
      check("rst_ready", ready, 1);
      check("rst_master_write", master_write, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done_write, 0);
      check("rst_address", master_address, 32'h0);
      rst = 1'b0;

      // 1) full run of 8 at 0x1000, no stalls
      load_addr(32'h0000_1000);
      wc = write_cycles;
      for (int i = 1; i <= 8; i++) send_pixel(24'(i));
      check("t1_write_latency", master_write, 1);
      check("t1_busy", busy, 1);
      check("t1_ready_low", ready, 0);
      check("t1_first_addr", master_address, 32'h1000);
      wait_done("t1_done", 40);
      check("t1_write_cycles", write_cycles - wc, 8);
      check("t1_next_addr", master_address, 32'h1020);

      // 2) partial run + flush, then flush with empty buffer
      wc = write_cycles;
      send_pixel(24'hAA0000);
      send_pixel(24'hBB0000);
      send_pixel(24'hCC0000);
      do_flush();
      check("t2_write_latency", master_write, 1);
      wait_done("t2_done", 40);
      check("t2_write_cycles", write_cycles - wc, 3);
      wc = write_cycles;
      dc = done_cnt;
      do_flush();
      repeat (5) tick();
      check("t2_empty_flush_writes", write_cycles - wc, 0);
      check("t2_empty_flush_done", done_cnt - dc, 0);

      // 3) five-cycle stall on beat 2
      load_addr(32'h0000_2000);
      wc = write_cycles;
      for (int i = 0; i < 8; i++) send_pixel(24'h300000 + 24'(i));
      tick();
      master_waitrequest = 1'b1;
      repeat (5) tick();
      master_waitrequest = 1'b0;
      wait_done("t3_done", 40);
      check("t3_write_cycles", write_cycles - wc, 13);

      // 4) pixel_valid held high through the drain
      load_addr(32'h0000_3000);
      for (int i = 0; i < 8; i++) send_pixel(24'h400000 + 24'(i));
      pixel_valid = 1'b1;
      pixel_in    = 24'hEEEEEE;
      wait_done("t4_done", 40);
      pixel_valid = 1'b0;
      wc = write_cycles;
      send_pixel(24'h123456);
      do_flush();
      wait_done("t4_single_done", 20);
      check("t4_write_cycles", write_cycles - wc, 1);

      // 5) address wrap
      load_addr(32'hFFFF_FFF8);
      for (int i = 0; i < 4; i++) send_pixel(24'h500000 + 24'(i));
      do_flush();
      check("t5_first_addr", master_address, 32'hFFFF_FFF8);
      wait_done("t5_done", 40);
      check("t5_wrapped_addr", master_address, 32'h0000_0008);

      // 6) reset after beat 3 of a drain
      load_addr(32'h0000_4000);
      for (int i = 0; i < 8; i++) send_pixel(24'h600000 + 24'(i));
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() <= 5) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      check("t6_three_beats", got, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_master_write", master_write, 0);
      check("t6_ready", ready, 1);
      check("t6_busy", busy, 0);
      check("t6_abandoned", exp_q.size(), 5);
      exp_q.delete();
      wc = write_cycles;
      do_flush();
      repeat (3) tick();
      check("t6_count_cleared", write_cycles - wc, 0);
      load_addr(32'h0000_5000);
      wc = write_cycles;
      for (int i = 0; i < 8; i++) send_pixel(24'h700000 + 24'(i));
      wait_done("t6_done", 40);
      check("t6_write_cycles", write_cycles - wc, 8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
